// File: rtl/cdma_dc_rsp_seq.sv
// Direct-conv response sequencer: pairs each DMA read response with its info
// entry and writes the selected 256b atoms into a circular CBUF entry window.
`timescale 1ns/1ps
module cdma_dc_rsp_seq #(
    parameter int DMA_W  = 512,
    parameter int ATOM_W = 256,
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              info_rd_req,
    output logic              info_rd_ready,
    input  logic [5:0]        info_rd_data,
    input  logic              dma_rsp_valid,
    output logic              dma_rsp_ready,
    input  logic [DMA_W-1:0]  dma_rsp_data,
    input  logic [ADDR_W-1:0] cfg_wr_base,
    input  logic [ADDR_W:0]   cfg_wr_entries,
    input  logic              layer_start,
    output logic              cbuf_wr_en,
    output logic [ADDR_W-1:0] cbuf_wr_addr,
    output logic [ATOM_W-1:0] cbuf_wr_data,
    output logic              stripe_done,
    output logic [CNT_W-1:0]  atom_cnt,
    output logic              err_mask_zero,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    // Handshake: an info entry and a DMA response are popped together, in the
    // single cycle where both are valid and the FSM can start a new entry;
    // info_rd_ready and dma_rsp_ready are the same accept signal.

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BEAT_LO = 2'd1,
        ST_BEAT_HI = 2'd2,
        ST_NULL    = 2'd3
    } state_e;

    localparam logic [ADDR_W:0]   ENT_ONE = 1;
    localparam logic [ADDR_W-1:0] OFF_ONE = 1;
    localparam logic [CNT_W-1:0]  CNT_ONE = 1;

    state_e            state_q;
    state_e            first_state;
    logic [DMA_W-1:0]  data_q;
    logic [1:0]        mask_q;
    logic              last_q;
    logic [ADDR_W-1:0] offset_q, offset_d;
    logic [CNT_W-1:0]  atom_cnt_q, atom_cnt_d;
    logic              err_q;
    logic              final_beat;
    logic              accept;
    logic              wr_en;
    logic              unused_rsvd;

    assign unused_rsvd = ^info_rd_data[5:3];

    // Final beat is where the next entry may be accepted without a bubble.
    assign final_beat = (state_q == ST_BEAT_LO && !mask_q[1]) ||
                        (state_q == ST_BEAT_HI) || (state_q == ST_NULL);
    assign accept     = info_rd_req & dma_rsp_valid & ~layer_start &
                        ((state_q == ST_IDLE) | final_beat);
    assign wr_en      = (state_q == ST_BEAT_LO) | (state_q == ST_BEAT_HI);

    always_comb begin
        if (info_rd_data[0]) begin
            first_state = ST_BEAT_LO;
        end else if (info_rd_data[1]) begin
            first_state = ST_BEAT_HI;
        end else begin
            first_state = ST_NULL;
        end
    end

    always_comb begin
        offset_d   = offset_q;
        atom_cnt_d = atom_cnt_q;
        if (wr_en) begin
            offset_d   = ({1'b0, offset_q} == cfg_wr_entries - ENT_ONE) ? '0 : offset_q + OFF_ONE;
            atom_cnt_d = atom_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            mask_q     <= '0;
            last_q     <= 1'b0;
            offset_q   <= '0;
            atom_cnt_q <= '0;
            err_q      <= 1'b0;
        end else if (layer_start) begin
            // Any beats still pending for the current entry are dropped.
            state_q    <= ST_IDLE;
            offset_q   <= '0;
            atom_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            offset_q   <= offset_d;
            atom_cnt_q <= atom_cnt_d;
            if (accept) begin
                data_q  <= dma_rsp_data;
                mask_q  <= info_rd_data[1:0];
                last_q  <= info_rd_data[2];
                state_q <= first_state;
                if (info_rd_data[1:0] == 2'b00) begin
                    err_q <= 1'b1;
                end
            end else if (state_q == ST_BEAT_LO && mask_q == 2'b11) begin
                state_q <= ST_BEAT_HI;
            end else if (final_beat) begin
                state_q <= ST_IDLE;
            end
        end
    end

    assign info_rd_ready = accept;
    assign dma_rsp_ready = accept;
    assign cbuf_wr_en    = wr_en;
    assign cbuf_wr_addr  = wr_en ? cfg_wr_base + offset_q : '0;
    assign cbuf_wr_data  = (state_q == ST_BEAT_LO) ? data_q[ATOM_W-1:0] :
                           (state_q == ST_BEAT_HI) ? data_q[DMA_W-1:ATOM_W] : '0;
    assign stripe_done   = final_beat & last_q;
    assign atom_cnt      = atom_cnt_q;
    assign err_mask_zero = err_q;
    assign busy          = (state_q != ST_IDLE);
    assign dbg_state     = state_q;

endmodule
